maxnet_loader: RTL and testbench

Upstream front-end for the Maxnet winner-take-all core. It accepts IEEE-754 single-precision activations one word at a time over a valid/ready stream and buffers four of them. It then drives them onto Maxnet's `x1..x4` inputs with a one-cycle `start` pulse and waits for `done` under a watchdog. The Maxnet result is returned on a valid/ready output stream together with an error flag.

---
 rtl/maxnet_defs.sv | 16 +
 rtl/fp32_sanitize.sv | 18 +
 rtl/maxnet_loader.sv | 122 ++++++++++++
 tb/tb_maxnet_loader.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/maxnet_defs.sv
// Shared definitions for the Maxnet front-end: fp32 field layout and the
// loader state encoding used by the loader, downstream consumers and benches.
package maxnet_defs;
  localparam int WORD_W   = 32;
  localparam int SIGN_BIT = 31;
  localparam int EXP_MSB  = 30;
  localparam int EXP_LSB  = 23;
  localparam logic [7:0] EXP_ALL_ONES = 8'hFF;

  typedef enum logic [1:0] {
    ST_LOAD  = 2'd0,
    ST_START = 2'd1,
    ST_WAIT  = 2'd2,
    ST_OUT   = 2'd3
  } mx_state_e;
endpackage

// File: rtl/fp32_sanitize.sv
// Combinational fp32 scrubber: negatives and Inf/NaN become +0 and flag bad;
// -0 is folded to +0 silently, denormals pass untouched.
module fp32_sanitize
  import maxnet_defs::*;
(
  input  logic [WORD_W-1:0] din_i,
  output logic [WORD_W-1:0] dout_o,
  output logic              bad_o
);
  logic sign, inf_nan, neg_zero;

  assign sign     = din_i[SIGN_BIT];
  assign inf_nan  = (din_i[EXP_MSB:EXP_LSB] == EXP_ALL_ONES);
  assign neg_zero = sign && (din_i[SIGN_BIT-1:0] == '0);

  assign dout_o = (sign || inf_nan) ? '0 : din_i;
  assign bad_o  = (sign || inf_nan) && !neg_zero;
endmodule

// File: rtl/maxnet_loader.sv
// Buffers four sanitized fp32 activations, kicks Maxnet with a start pulse,
// waits for done under a watchdog and returns the result on a ready/valid stream.
module maxnet_loader #(
  parameter int WORD_W  = 32,
  parameter int TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WORD_W-1:0] in_data,
  output logic              mx_start,
  output logic [WORD_W-1:0] mx_x1,
  output logic [WORD_W-1:0] mx_x2,
  output logic [WORD_W-1:0] mx_x3,
  output logic [WORD_W-1:0] mx_x4,
  input  logic              mx_done,
  input  logic [WORD_W-1:0] mx_res,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WORD_W-1:0] out_data,
  output logic              out_err
);
  import maxnet_defs::*;

  localparam int WD_W = $clog2(TIMEOUT);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

  mx_state_e state_q, state_d;
  logic [1:0]              cnt_q, cnt_d;
  logic                    err_q, err_d;
  logic [WD_W-1:0]         wdog_q, wdog_d;
  logic [3:0][WORD_W-1:0]  slot_q, slot_d;
  logic [WORD_W-1:0]       out_data_q, out_data_d;
  logic                    mx_start_q, out_valid_q, out_err_q;
  logic [WORD_W-1:0]       san_word;
  logic                    san_bad;

  fp32_sanitize u_san (
    .din_i  (in_data),
    .dout_o (san_word),
    .bad_o  (san_bad)
  );

  // Held low through reset so nothing is accepted on a reset edge.
  assign in_ready = rst && (state_q == ST_LOAD);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    err_d      = err_q;
    wdog_d     = wdog_q;
    slot_d     = slot_q;
    out_data_d = out_data_q;
    case (state_q)
      ST_LOAD: begin
        if (in_valid && in_ready) begin
          slot_d[cnt_q] = san_word;
          err_d         = err_q | san_bad;
          cnt_d         = cnt_q + 2'd1;
          if (cnt_q == 2'd3) state_d = ST_START;
        end
      end
      ST_START: begin
        wdog_d  = '0;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        wdog_d = wdog_q + 1'b1;
        // done takes priority over a coincident timeout
        if (mx_done) begin
          out_data_d = mx_res;
          state_d    = ST_OUT;
        end else if (wdog_q == WD_LAST) begin
          out_data_d = '0;
          err_d      = 1'b1;
          state_d    = ST_OUT;
        end
      end
      ST_OUT: begin
        if (out_ready) begin
          err_d   = 1'b0;
          state_d = ST_LOAD;
        end
      end
      default: state_d = ST_LOAD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= ST_LOAD;
      cnt_q       <= '0;
      err_q       <= 1'b0;
      wdog_q      <= '0;
      slot_q      <= '0;
      out_data_q  <= '0;
      mx_start_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      err_q       <= err_d;
      wdog_q      <= wdog_d;
      slot_q      <= slot_d;
      out_data_q  <= out_data_d;
      mx_start_q  <= (state_d == ST_START);
      out_valid_q <= (state_d == ST_OUT);
      out_err_q   <= (state_d == ST_OUT) && err_d;
    end
  end

  assign mx_start  = mx_start_q;
  assign mx_x1     = slot_q[0];
  assign mx_x2     = slot_q[1];
  assign mx_x3     = slot_q[2];
  assign mx_x4     = slot_q[3];
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_err   = out_err_q;
endmodule

// File: tb/tb_maxnet_loader.sv
// Directed bench for maxnet_loader with an inline Maxnet stub driven from tasks.
module tb_maxnet_loader;
  logic        clk = 1'b0, rst = 1'b0;
  logic        in_valid = 1'b0, in_ready;
  logic [31:0] in_data = '0;
  logic        mx_start, mx_done = 1'b0;
  logic [31:0] mx_x1, mx_x2, mx_x3, mx_x4, mx_res = '0;
  logic        out_valid, out_ready = 1'b0, out_err;
  logic [31:0] out_data;

  int n_chk = 0, n_pass = 0, n_start = 0;

  maxnet_loader #(.WORD_W(32), .TIMEOUT(64)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .mx_start(mx_start), .mx_x1(mx_x1), .mx_x2(mx_x2), .mx_x3(mx_x3), .mx_x4(mx_x4),
    .mx_done(mx_done), .mx_res(mx_res), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_err(out_err)
  );

  always #5 clk = ~clk;
  always @(negedge clk) if (mx_start) n_start++;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h exp %h", tag, got, exp);
  endtask

  task automatic tick;
    @(posedge clk); #1;
  endtask

  task automatic send(input logic [31:0] w, input int gap);
    in_valid = 1'b0;
    repeat (gap) tick;
    in_valid = 1'b1;
    in_data  = w;
    tick;
    in_valid = 1'b0;
  endtask

  task automatic chk_idle_zero(input string tag);
    chk({tag, "_x1"}, mx_x1, 32'h0);
    chk({tag, "_x2"}, mx_x2, 32'h0);
    chk({tag, "_x3"}, mx_x3, 32'h0);
    chk({tag, "_x4"}, mx_x4, 32'h0);
    chk({tag, "_data"}, out_data, 32'h0);
    chk({tag, "_start"}, mx_start, 0);
    chk({tag, "_oval"}, out_valid, 0);
    chk({tag, "_oerr"}, out_err, 0);
    chk({tag, "_irdy"}, in_ready, 0);
  endtask

  // Loads four words, then answers done dly cycles into WAIT (or lets it time out at dly=63).
  task automatic run_frame(input string tag, input logic [3:0][31:0] w,
                           input logic [3:0][31:0] ex, input int gap, input int dly,
                           input bit give_done, input logic [31:0] res,
                           input logic [31:0] exp_data, input logic exp_err);
    int s0;
    s0 = n_start;
    for (int i = 0; i < 4; i++) begin
      send(w[i], gap);
      if (i < 3) chk({tag, "_nostart"}, mx_start, 0);
    end
    chk({tag, "_start"}, mx_start, 1);
    chk({tag, "_irdy0"}, in_ready, 0);
    chk({tag, "_x1"}, mx_x1, ex[0]);
    chk({tag, "_x2"}, mx_x2, ex[1]);
    chk({tag, "_x3"}, mx_x3, ex[2]);
    chk({tag, "_x4"}, mx_x4, ex[3]);
    tick;
    chk({tag, "_startpulse"}, mx_start, 0);
    repeat (dly) tick;
    chk({tag, "_oval_pre"}, out_valid, 0);
    chk({tag, "_x4_hold"}, mx_x4, ex[3]);
    if (give_done) begin
      mx_done = 1'b1;
      mx_res  = res;
    end
    tick;
    mx_done = 1'b0;
    chk({tag, "_oval"}, out_valid, 1);
    chk({tag, "_data"}, out_data, exp_data);
    chk({tag, "_err"}, out_err, exp_err);
    chk({tag, "_nstart"}, n_start - s0, 1);
  endtask

  task automatic handshake(input string tag);
    out_ready = 1'b1;
    tick;
    out_ready = 1'b0;
    chk({tag, "_oval_clr"}, out_valid, 0);
    chk({tag, "_irdy"}, in_ready, 1);
  endtask

  logic [31:0] hold_d, hold_x1;
  int s1;

  initial begin
    // reset
    tick; tick;
    chk_idle_zero("rst");
    rst = 1'b1;
    tick;
    chk("rst_rel_irdy", in_ready, 1);

    run_frame("nom", {32'h3F4CCCCD, 32'h3F19999A, 32'h3ECCCCCD, 32'h3E4CCCCD},
              {32'h3F4CCCCD, 32'h3F19999A, 32'h3ECCCCCD, 32'h3E4CCCCD},
              0, 19, 1, 32'h3E000000, 32'h3E000000, 0);
    handshake("nom");

    run_frame("san", {32'h3F800000, 32'h80000000, 32'h7FC00000, 32'hBF000000},
              {32'h3F800000, 32'h0, 32'h0, 32'h0},
              0, 2, 1, 32'h3F800000, 32'h3F800000, 1);
    handshake("san");

    // -0, denormal and max finite are clean; gapped input
    run_frame("gap", {32'h3F000000, 32'h7F7FFFFF, 32'h00000001, 32'h80000000},
              {32'h3F000000, 32'h7F7FFFFF, 32'h00000001, 32'h0},
              3, 0, 1, 32'h00000001, 32'h00000001, 0);
    handshake("gap");

    run_frame("tmo", {32'h3F800000, 32'h3F000000, 32'h3E800000, 32'h3E000000},
              {32'h3F800000, 32'h3F000000, 32'h3E800000, 32'h3E000000},
              1, 63, 0, 32'h0, 32'h0, 1);
    handshake("tmo");

    run_frame("tmoeq", {32'h40000000, 32'h3F800000, 32'h3F000000, 32'h3E800000},
              {32'h40000000, 32'h3F800000, 32'h3F000000, 32'h3E800000},
              2, 63, 1, 32'h3F123456, 32'h3F123456, 0);

    // backpressure with a pending upstream word and spurious done
    hold_d  = out_data;
    hold_x1 = mx_x1;
    in_valid = 1'b1;
    in_data  = 32'h3DCCCCCD;
    for (int i = 0; i < 10; i++) begin
      mx_done = i[0];
      mx_res  = 32'hDEAD0000 + i;
      tick;
      chk("bp_oval", out_valid, 1);
      chk("bp_data", out_data, hold_d);
      chk("bp_err", out_err, 0);
      chk("bp_irdy", in_ready, 0);
      chk("bp_x1", mx_x1, hold_x1);
    end
    mx_done = 1'b0;
    handshake("bp");
    run_frame("bpnext", {32'h3E99999A, 32'h3E4CCCCD, 32'h3F000000, 32'h3DCCCCCD},
              {32'h3E99999A, 32'h3E4CCCCD, 32'h3F000000, 32'h3DCCCCCD},
              0, 5, 1, 32'h3E4CCCCD, 32'h3E4CCCCD, 0);
    handshake("bpnext");

    // reset after two words
    s1 = n_start;
    send(32'h3F800000, 0);
    send(32'h3F000000, 0);
    rst = 1'b0;
    tick;
    chk_idle_zero("rstmid");
    rst = 1'b1;
    tick;
    chk("rstmid_irdy", in_ready, 1);
    chk("rstmid_nostart", n_start - s1, 0);
    run_frame("postrst", {32'h3E000000, 32'h3E800000, 32'h3F000000, 32'h3F400000},
              {32'h3E000000, 32'h3E800000, 32'h3F000000, 32'h3F400000},
              0, 3, 1, 32'h3F400000, 32'h3F400000, 0);
    handshake("postrst");

    // reset during WAIT
    for (int i = 0; i < 4; i++) send(32'h3F800000, 0);
    tick; tick; tick;
    rst = 1'b0;
    tick;
    chk_idle_zero("rstwait");
    rst = 1'b1;
    tick;
    chk("rstwait_irdy", in_ready, 1);
    chk("rstwait_oval", out_valid, 0);
    run_frame("postwait", {32'h3F800000, 32'hFF800000, 32'h3F000000, 32'h3E800000},
              {32'h3F800000, 32'h0, 32'h3F000000, 32'h3E800000},
              1, 10, 1, 32'h3F800000, 32'h3F800000, 1);
    handshake("postwait");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
